// File: rtl/sr_pulse_pkg.sv
// Shared state encoding and default sizing for the SR flip-flop pulse driver.
package sr_pulse_pkg;

  localparam int unsigned DefaultWidth  = 16;
  localparam int unsigned DefaultPulseW = 2;

  typedef enum logic [2:0] {
    StIdle,
    StSetPulse,
    StHighWait,
    StResetPulse,
    StLowWait
  } state_e;

endpackage

// File: rtl/sr_pulse_counter.sv
// Loadable down-counter that saturates at zero; load has priority over decrement.
module sr_pulse_counter
  import sr_pulse_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] count_o,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/sr_pulse_driver.sv
// Drives set/reset pulses for an external SR flip-flop with programmable high/low phases.
// Optional one-shot mode (one_shot_i, done_o) is built when SR_PULSE_ONESHOT_EN is defined.
module sr_pulse_driver
  import sr_pulse_pkg::*;
#(
  parameter int unsigned WIDTH   = DefaultWidth,
  parameter int unsigned PULSE_W = DefaultPulseW
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic [WIDTH-1:0] high_cycles_i,
  input  logic [WIDTH-1:0] low_cycles_i,
`ifdef SR_PULSE_ONESHOT_EN
  input  logic             one_shot_i,
  output logic             done_o,
`endif
  output logic             set_out_o,
  output logic             reset_out_o,
  output logic             phase_o,
  output logic             busy_o
);

  localparam logic [WIDTH-1:0] PulseLen = WIDTH'(PULSE_W);
  localparam logic [WIDTH-1:0] One      = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] high_len_q, low_len_q;
  logic [WIDTH-1:0] high_clamped, low_clamped;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] load_val;
  logic             cnt_zero, load;
  logic             enter_set, enter_reset, run_done;
  logic             stop_q, stop_now;
  logic             set_q, reset_q, phase_q, busy_q;
  logic             oneshot_run, armed;

  assign high_clamped = (high_cycles_i < PulseLen) ? PulseLen : high_cycles_i;
  assign low_clamped  = (low_cycles_i < PulseLen) ? PulseLen : low_cycles_i;
  // Once Enable has been seen low mid-run, the run winds down even if Enable returns.
  assign stop_now     = stop_q | ~enable_i;

  // The counter holds the cycles left in the current high or low phase, so the
  // last pulse cycle is reached when it equals (phase length - PULSE_W).
  always_comb begin
    state_d     = state_q;
    enter_set   = 1'b0;
    enter_reset = 1'b0;
    run_done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable_i && armed) enter_set = 1'b1;
      end
      StSetPulse: begin
        if (cnt == high_len_q - PulseLen) begin
          if (stop_now || cnt_zero) enter_reset = 1'b1;
          else                      state_d     = StHighWait;
        end
      end
      StHighWait: begin
        if (stop_now || cnt_zero) enter_reset = 1'b1;
      end
      StResetPulse: begin
        if (cnt == low_len_q - PulseLen) begin
          if (stop_now) begin
            state_d = StIdle;
          end else if (cnt_zero) begin
            if (oneshot_run) begin
              state_d  = StIdle;
              run_done = 1'b1;
            end else begin
              enter_set = 1'b1;
            end
          end else begin
            state_d = StLowWait;
          end
        end
      end
      StLowWait: begin
        if (!enable_i) begin
          state_d = StIdle;
        end else if (cnt_zero) begin
          if (oneshot_run) begin
            state_d  = StIdle;
            run_done = 1'b1;
          end else begin
            enter_set = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (enter_set)   state_d = StSetPulse;
    if (enter_reset) state_d = StResetPulse;
  end

  assign load     = enter_set | enter_reset;
  assign load_val = enter_set ? (high_clamped - One) : (low_clamped - One);

  sr_pulse_counter #(
    .WIDTH(WIDTH)
  ) u_counter (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (load),
    .load_val_i(load_val),
    .dec_i     (state_q != StIdle),
    .count_o   (cnt),
    .zero_o    (cnt_zero)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      high_len_q <= '0;
      low_len_q  <= '0;
      stop_q     <= 1'b0;
      set_q      <= 1'b0;
      reset_q    <= 1'b0;
      phase_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (enter_set)   high_len_q <= high_clamped;
      if (enter_reset) low_len_q  <= low_clamped;
      if (enter_set) begin
        stop_q <= 1'b0;
      end else if ((state_q != StIdle) && !enable_i) begin
        stop_q <= 1'b1;
      end
      set_q   <= (state_d == StSetPulse);
      reset_q <= (state_d == StResetPulse);
      phase_q <= (state_d == StSetPulse) || (state_d == StHighWait);
      busy_q  <= (state_d != StIdle);
    end
  end

`ifdef SR_PULSE_ONESHOT_EN
  logic oneshot_q, armed_q, done_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      oneshot_q <= 1'b0;
      armed_q   <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      if (enter_set) oneshot_q <= one_shot_i;
      // A finished one-shot stays idle until Enable is seen low again.
      if (!enable_i)     armed_q <= 1'b1;
      else if (run_done) armed_q <= 1'b0;
      done_q <= run_done;
    end
  end

  assign oneshot_run = oneshot_q;
  assign armed       = armed_q;
  assign done_o      = done_q;
`else
  logic unused_run_done;

  assign oneshot_run     = 1'b0;
  assign armed           = 1'b1;
  assign unused_run_done = run_done;
`endif

  assign set_out_o   = set_q;
  assign reset_out_o = reset_q;
  assign phase_o     = phase_q;
  assign busy_o      = busy_q;

endmodule
